// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared encodings for the memory-access / MEM-WB stage.
// Revision: 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

    localparam logic [3:0] C_WSTRB_NONE    = 4'b0000;
    localparam logic [3:0] C_WSTRB_LO_HALF = 4'b0011;
    localparam logic [3:0] C_WSTRB_HI_HALF = 4'b1100;
    localparam logic [3:0] C_WSTRB_WORD    = 4'b1111;

    // Size code 11 is treated as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = offset[0];
            default: mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module  : load_align
// Brief   : Selects the addressed byte/half lane of a load word and extends it.
// Revision: 1.0 - initial release
// ============================================================================
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[8*i_offset +: 8];
    assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_size)
            SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_wb_stage
// Brief   : Data-memory access over a valid/ready bus plus the MEM/WB register.
// Revision: 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] EX_MEM_ALU_result,
    input  logic [31:0] EX_MEM_rs2_data,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_regwrite,
    input  logic        EX_MEM_memtoreg,
    input  logic        EX_MEM_memread,
    input  logic        EX_MEM_memwrite,
    input  logic [31:0] EX_MEM_pc,
    input  logic        EX_MEM_unconditional_jmp,
    input  logic [1:0]  EX_MEM_size,
    input  logic        EX_MEM_unsigned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        MEM_stall,
    output logic [31:0] MEM_WB_data,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_regwrite,
    output logic [31:0] MEM_WB_pc,
    output logic        MEM_WB_misalign
);

    mem_state_t  r_state;
    mem_state_t  w_state_next;

    logic [31:0] r_addr;
    logic [4:0]  r_rd;
    logic        r_regwrite;
    logic        r_memtoreg;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_pc;

    logic        w_access;
    logic        w_misalign;
    logic        w_rd_nonzero;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    assign w_access     = EX_MEM_memread | EX_MEM_memwrite;
    assign w_misalign   = w_access & is_misaligned(EX_MEM_size, EX_MEM_ALU_result[1:0]);
    assign w_rd_nonzero = (EX_MEM_rd != 5'd0);
    assign MEM_stall    = (r_state == ST_BUSY);

    always_comb begin
        w_wstrb = C_WSTRB_WORD;
        w_wdata = EX_MEM_rs2_data;
        case (EX_MEM_size)
            SZ_BYTE: begin
                w_wstrb = 4'b0001 << EX_MEM_ALU_result[1:0];
                w_wdata = {4{EX_MEM_rs2_data[7:0]}};
            end
            SZ_HALF: begin
                w_wstrb = EX_MEM_ALU_result[1] ? C_WSTRB_HI_HALF : C_WSTRB_LO_HALF;
                w_wdata = {2{EX_MEM_rs2_data[15:0]}};
            end
            default: begin
                w_wstrb = C_WSTRB_WORD;
                w_wdata = EX_MEM_rs2_data;
            end
        endcase
    end

    load_align u_load_align (
        .i_rdata    (dmem_rdata),
        .i_offset   (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_access && !w_misalign) w_state_next = ST_BUSY;
            ST_BUSY: if (dmem_ready)              w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= 32'd0;
            dmem_wdata      <= 32'd0;
            dmem_wstrb      <= C_WSTRB_NONE;
            MEM_WB_data     <= 32'd0;
            MEM_WB_rd       <= 5'd0;
            MEM_WB_regwrite <= 1'b0;
            MEM_WB_pc       <= 32'd0;
            MEM_WB_misalign <= 1'b0;
            r_addr          <= 32'd0;
            r_rd            <= 5'd0;
            r_regwrite      <= 1'b0;
            r_memtoreg      <= 1'b0;
            r_size          <= SZ_BYTE;
            r_unsigned      <= 1'b0;
            r_pc            <= 32'd0;
        end else begin
            MEM_WB_misalign <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_access) begin
                        MEM_WB_data     <= EX_MEM_unconditional_jmp ? EX_MEM_pc + 32'd4
                                                                    : EX_MEM_ALU_result;
                        MEM_WB_rd       <= EX_MEM_rd;
                        MEM_WB_regwrite <= EX_MEM_regwrite & w_rd_nonzero;
                        MEM_WB_pc       <= EX_MEM_pc;
                    end else if (w_misalign) begin
                        MEM_WB_data     <= EX_MEM_ALU_result;
                        MEM_WB_rd       <= EX_MEM_rd;
                        MEM_WB_regwrite <= 1'b0;
                        MEM_WB_pc       <= EX_MEM_pc;
                        MEM_WB_misalign <= 1'b1;
                    end else begin
                        // Issue the access; write-back sees a bubble until it completes.
                        dmem_req        <= 1'b1;
                        dmem_we         <= EX_MEM_memwrite;
                        dmem_addr       <= {EX_MEM_ALU_result[31:2], 2'b00};
                        dmem_wdata      <= w_wdata;
                        dmem_wstrb      <= EX_MEM_memwrite ? w_wstrb : C_WSTRB_NONE;
                        MEM_WB_regwrite <= 1'b0;
                        r_addr          <= EX_MEM_ALU_result;
                        r_rd            <= EX_MEM_rd;
                        r_regwrite      <= EX_MEM_regwrite & ~EX_MEM_memwrite & w_rd_nonzero;
                        r_memtoreg      <= EX_MEM_memtoreg;
                        r_size          <= EX_MEM_size;
                        r_unsigned      <= EX_MEM_unsigned;
                        r_pc            <= EX_MEM_pc;
                    end
                end
                ST_BUSY: begin
                    if (dmem_ready) begin
                        dmem_req        <= 1'b0;
                        MEM_WB_data     <= r_memtoreg ? w_load_data : r_addr;
                        MEM_WB_rd       <= r_rd;
                        MEM_WB_regwrite <= r_regwrite;
                        MEM_WB_pc       <= r_pc;
                    end
                end
                default: dmem_req <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_wb_stage
// Brief   : Directed plus randomized self-checking bench for mem_wb_stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] EX_MEM_ALU_result, EX_MEM_rs2_data, EX_MEM_pc;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_regwrite, EX_MEM_memtoreg, EX_MEM_memread, EX_MEM_memwrite;
    logic        EX_MEM_unconditional_jmp, EX_MEM_unsigned;
    logic [1:0]  EX_MEM_size;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        MEM_stall;
    logic [31:0] MEM_WB_data, MEM_WB_pc;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_regwrite, MEM_WB_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk                      (clk),
        .reset                    (reset),
        .EX_MEM_ALU_result        (EX_MEM_ALU_result),
        .EX_MEM_rs2_data          (EX_MEM_rs2_data),
        .EX_MEM_rd                (EX_MEM_rd),
        .EX_MEM_regwrite          (EX_MEM_regwrite),
        .EX_MEM_memtoreg          (EX_MEM_memtoreg),
        .EX_MEM_memread           (EX_MEM_memread),
        .EX_MEM_memwrite          (EX_MEM_memwrite),
        .EX_MEM_pc                (EX_MEM_pc),
        .EX_MEM_unconditional_jmp (EX_MEM_unconditional_jmp),
        .EX_MEM_size              (EX_MEM_size),
        .EX_MEM_unsigned          (EX_MEM_unsigned),
        .dmem_req                 (dmem_req),
        .dmem_we                  (dmem_we),
        .dmem_addr                (dmem_addr),
        .dmem_wdata               (dmem_wdata),
        .dmem_wstrb               (dmem_wstrb),
        .dmem_ready               (dmem_ready),
        .dmem_rdata               (dmem_rdata),
        .MEM_stall                (MEM_stall),
        .MEM_WB_data              (MEM_WB_data),
        .MEM_WB_rd                (MEM_WB_rd),
        .MEM_WB_regwrite          (MEM_WB_regwrite),
        .MEM_WB_pc                (MEM_WB_pc),
        .MEM_WB_misalign          (MEM_WB_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    // Reference: shift the addressed bytes down, mask, then sign-extend by adding the high fill.
    function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] v;
        int off;
        off = int'(addr % 4);
        v = rdata;
        if (size_bytes(size) == 1) begin
            v = (rdata >> (off * 8)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (size_bytes(size) == 2) begin
            v = (rdata >> (off * 8)) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_wstrb(input logic [31:0] addr, input logic [1:0] size);
        int n;
        n = size_bytes(size);
        return (n == 4) ? 32'hF : (((32'd1 << n) - 32'd1) << (addr % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] rs2, input logic [1:0] size);
        int n;
        n = size_bytes(size);
        if (n == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
        return rs2;
    endfunction

    task automatic drive_nop();
        EX_MEM_ALU_result = 32'd0; EX_MEM_rs2_data = 32'd0; EX_MEM_rd = 5'd0;
        EX_MEM_regwrite = 1'b0; EX_MEM_memtoreg = 1'b0; EX_MEM_memread = 1'b0;
        EX_MEM_memwrite = 1'b0; EX_MEM_pc = 32'd0; EX_MEM_unconditional_jmp = 1'b0;
        EX_MEM_size = 2'd0; EX_MEM_unsigned = 1'b0;
    endtask

    task automatic drive_garbage();
        EX_MEM_ALU_result = $urandom; EX_MEM_rs2_data = $urandom; EX_MEM_rd = 5'($urandom);
        EX_MEM_regwrite = 1'($urandom); EX_MEM_memtoreg = 1'($urandom);
        EX_MEM_memread = 1'($urandom); EX_MEM_memwrite = 1'($urandom);
        EX_MEM_pc = $urandom; EX_MEM_unconditional_jmp = 1'($urandom);
        EX_MEM_size = 2'($urandom); EX_MEM_unsigned = 1'($urandom);
    endtask

    task automatic run_instr(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                             input logic rw, input logic mr, input logic mw,
                             input logic [31:0] pc, input logic jmp, input logic [1:0] size,
                             input logic uns, input int dly, input logic [31:0] rdata);
        logic acc, mis, exp_rw;
        int stalls;
        acc = mr | mw;
        mis = acc && ((alu % size_bytes(size)) != 0);
        EX_MEM_ALU_result = alu; EX_MEM_rs2_data = rs2; EX_MEM_rd = rd;
        EX_MEM_regwrite = rw; EX_MEM_memtoreg = mr; EX_MEM_memread = mr;
        EX_MEM_memwrite = mw; EX_MEM_pc = pc; EX_MEM_unconditional_jmp = jmp;
        EX_MEM_size = size; EX_MEM_unsigned = uns;
        @(posedge clk); #1;
        if (!acc) begin
            chk("alu_data", MEM_WB_data, jmp ? pc + 32'd4 : alu);
            chk("alu_regwrite", 32'(MEM_WB_regwrite), 32'(rw && rd != 5'd0));
            chk("alu_rd", 32'(MEM_WB_rd), 32'(rd));
            chk("alu_pc", MEM_WB_pc, pc);
            chk("alu_stall", 32'(MEM_stall), 32'd0);
            chk("alu_req", 32'(dmem_req), 32'd0);
        end else if (mis) begin
            chk("mis_req", 32'(dmem_req), 32'd0);
            chk("mis_stall", 32'(MEM_stall), 32'd0);
            chk("mis_regwrite", 32'(MEM_WB_regwrite), 32'd0);
            chk("mis_flag", 32'(MEM_WB_misalign), 32'd1);
            chk("mis_pc", MEM_WB_pc, pc);
            drive_nop();
            @(posedge clk); #1;
            chk("mis_flag_clear", 32'(MEM_WB_misalign), 32'd0);
        end else begin
            chk("acc_req", 32'(dmem_req), 32'd1);
            chk("acc_stall", 32'(MEM_stall), 32'd1);
            chk("acc_we", 32'(dmem_we), 32'(mw));
            chk("acc_addr", dmem_addr, alu & 32'hFFFF_FFFC);
            chk("acc_wstrb", 32'(dmem_wstrb), mw ? exp_wstrb(alu, size) : 32'd0);
            if (mw) chk("acc_wdata", dmem_wdata, exp_wdata(rs2, size));
            chk("acc_bubble", 32'(MEM_WB_regwrite), 32'd0);
            stalls = 1;
            drive_garbage();
            for (int i = 0; i < dly; i++) begin
                dmem_ready = 1'b0;
                dmem_rdata = $urandom;
                @(posedge clk); #1;
                if (MEM_stall) stalls++;
                chk("hold_addr", dmem_addr, alu & 32'hFFFF_FFFC);
                chk("hold_req", 32'(dmem_req), 32'd1);
            end
            dmem_ready = 1'b1;
            dmem_rdata = rdata;
            @(posedge clk); #1;
            dmem_ready = 1'b0;
            dmem_rdata = $urandom;
            exp_rw = rw && !mw && rd != 5'd0;
            chk("done_stall_cycles", 32'(stalls), 32'(dly + 1));
            chk("done_stall", 32'(MEM_stall), 32'd0);
            chk("done_req", 32'(dmem_req), 32'd0);
            chk("done_regwrite", 32'(MEM_WB_regwrite), 32'(exp_rw));
            chk("done_rd", 32'(MEM_WB_rd), 32'(rd));
            chk("done_pc", MEM_WB_pc, pc);
            chk("done_misalign", 32'(MEM_WB_misalign), 32'd0);
            if (!mw) chk("done_load", MEM_WB_data, exp_load(rdata, alu, size, uns));
        end
    endtask

    initial begin
        int kind;
        logic [1:0] sz;
        reset = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
        drive_nop();
        @(posedge clk); #1;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(MEM_stall), 32'd0);
        chk("rst_data", MEM_WB_data, 32'd0);
        chk("rst_regwrite", 32'(MEM_WB_regwrite), 32'd0);
        chk("rst_wstrb", 32'(dmem_wstrb), 32'd0);
        reset = 1'b0;

        run_instr(32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 2'd2, 1'b0, 0, 32'd0);
        run_instr(32'h5555, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h44, 1'b0, 2'd2, 1'b0, 0, 32'd0);
        run_instr(32'h9999, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h48, 1'b1, 2'd2, 1'b0, 0, 32'd0);
        run_instr(32'h100, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0, 32'h4C, 1'b0, 2'd2, 1'b0, 2, 32'hDEADBEEF);
        run_instr(32'h103, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 32'h50, 1'b0, 2'd0, 1'b0, 0, 32'h80123456);
        run_instr(32'h103, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 32'h54, 1'b0, 2'd0, 1'b1, 1, 32'h80123456);
        run_instr(32'h202, 32'hABCD, 5'd8, 1'b1, 1'b0, 1'b1, 32'h58, 1'b0, 2'd1, 1'b0, 1, 32'd0);
        run_instr(32'h301, 32'h11223344, 5'd9, 1'b1, 1'b1, 1'b1, 32'h5C, 1'b0, 2'd0, 1'b0, 0, 32'd0);
        run_instr(32'h101, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0, 32'h60, 1'b0, 2'd2, 1'b0, 0, 32'd0);

        // Reset in the middle of an outstanding load.
        EX_MEM_ALU_result = 32'h100; EX_MEM_memread = 1'b1; EX_MEM_memtoreg = 1'b1;
        EX_MEM_regwrite = 1'b1; EX_MEM_rd = 5'd3; EX_MEM_size = 2'd2; EX_MEM_pc = 32'h64;
        @(posedge clk); #1;
        chk("rb_req", 32'(dmem_req), 32'd1);
        drive_nop();
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("rb_req_async", 32'(dmem_req), 32'd0);
        chk("rb_stall", 32'(MEM_stall), 32'd0);
        chk("rb_addr", dmem_addr, 32'd0);
        chk("rb_pc", MEM_WB_pc, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        chk("rb_ready_ignored_req", 32'(dmem_req), 32'd0);
        chk("rb_ready_ignored_stall", 32'(MEM_stall), 32'd0);
        chk("rb_ready_ignored_rw", 32'(MEM_WB_regwrite), 32'd0);

        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 3));
            sz = 2'($urandom);
            run_instr($urandom, $urandom, 5'($urandom), 1'($urandom),
                      kind == 1 || kind == 3, kind >= 2, $urandom, 1'($urandom),
                      sz, 1'($urandom), int'($urandom_range(0, 3)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register. Consumes the EX/MEM register outputs, performs data-memory loads and stores over a valid/ready bus with byte/half/word alignment, and registers the write-back value, destination and control for the register file. Freezes the upstream pipeline while a memory access is outstanding, and flags misaligned accesses.

## Interface
- No parameters; datapath fixed at 32 bits.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- EX_MEM_ALU_result  in  32  address or ALU result
- EX_MEM_rs2_data  in  32  store data
- EX_MEM_rd  in  5  destination register
- EX_MEM_regwrite / EX_MEM_memtoreg / EX_MEM_memread / EX_MEM_memwrite  in  1 each  control
- EX_MEM_pc  in  32  instruction pc
- EX_MEM_unconditional_jmp  in  1  write-back pc+4
- EX_MEM_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- EX_MEM_unsigned  in  1  zero-extend loads
- dmem_req  out  1  request valid (registered)
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables, 0 on loads
- dmem_ready  in  1  transfer accepted/completed
- dmem_rdata  in  32  load word, valid when dmem_ready
- MEM_stall  out  1  access outstanding; upstream must freeze
- MEM_WB_data  out  32  write-back value
- MEM_WB_rd  out  5
- MEM_WB_regwrite  out  1
- MEM_WB_pc  out  32
- MEM_WB_misalign  out  1  one-cycle misalignment flag

## Operation
- FSM states IDLE, BUSY. Reset -> IDLE.
- IDLE, no access (memread=memwrite=0): on edge, MEM_WB_* <= pass-through; MEM_WB_data = pc+4 if unconditional_jmp, else ALU_result.
- IDLE, aligned access: capture addr, wdata, wstrb, rd, regwrite, memtoreg, size, unsigned, pc into internal regs; dmem_req<=1; -> BUSY; MEM_WB_regwrite<=0 (bubble).
- memwrite and memread both set: treated as store; regwrite forced 0.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0. Misaligned: no request, stay IDLE, MEM_WB_regwrite<=0, MEM_WB_misalign<=1, MEM_WB_pc<=EX_MEM_pc.
- Stores: byte wstrb = 1<<addr[1:0], wdata = {4{rs2[7:0]}}; half wstrb = 0011/1100, wdata = {2{rs2[15:0]}}; word wstrb = 1111.
- BUSY: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb held constant until dmem_ready. On dmem_ready edge: dmem_req<=0, -> IDLE, MEM_WB_* <= captured ctrl; load data = lane selected by addr[1:0], sign- or zero-extended per size/unsigned.
- MEM_stall = (state==BUSY); EX_MEM_* ignored while BUSY. Upstream presents a new instruction only after MEM_stall falls.
- rd==0: MEM_WB_regwrite forced 0.
- dmem_ready in IDLE ignored.

## Timing
- All outputs registered except MEM_stall (decoded from state register).
- Reset values: every output 0, state IDLE. Reset mid-BUSY drops the access; dmem_req falls asynchronously.
- Non-memory instruction: 1-cycle latency to MEM_WB_*.
- Memory access issued in cycle N: dmem_req high from N+1; ready in cycle M >= N+1 gives MEM_WB valid after edge M, state IDLE in M+1; stall cycles = M-N.
- Back-to-back accesses: next request at earliest one cycle after completion (IDLE sample cycle).
- MEM_WB_misalign high exactly one cycle per misaligned instruction.

## Structure
- Package mem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state enum, wstrb constants.
- Sub-module load_align: combinational lane select plus sign/zero extend (rdata, addr[1:0], size, unsigned -> 32-bit data).

## Test plan
- ALU op rd=5, result 0x1234, no memory -> MEM_WB_data=0x1234, regwrite=1 after 1 cycle, MEM_stall never high.
- lw addr 0x100, ready after 3 cycles, rdata 0xDEADBEEF -> MEM_stall high 3 cycles, dmem_addr=0x100 stable, MEM_WB_data=0xDEADBEEF.
- lb addr 0x103, rdata 0x80xxxxxx signed -> 0xFFFFFF80; same with unsigned -> 0x00000080.
- sh rs2=0xABCD addr 0x202 -> wstrb=1100, wdata=0xABCDABCD, MEM_WB_regwrite=0.
- lw addr 0x101 -> no dmem_req, MEM_WB_misalign=1 for one cycle, MEM_WB_pc=EX_MEM_pc.
- reset asserted in BUSY -> dmem_req and all outputs 0 immediately; later ready ignored, IDLE.
